// File: rtl/rv_regs_pkg.sv
// Shared types and helpers for the FlexRV32 integer register file.
package rv_regs_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } regs_state_t;

  localparam int REGS_X0 = 0;

  function automatic int regs_aw(input int reg_cnt);
    return $clog2(reg_cnt);
  endfunction

endpackage

// File: rtl/rv_regfile_if.sv
// Decode/write-back side bus of the register file: read addresses, write port, read data, trace.
interface rv_regfile_if #(
  parameter int XLEN     = 32,
  parameter int REG_CNT  = 32,
  parameter int RD_PORTS = 2
) ();
  import rv_regs_pkg::*;

  localparam int AW = regs_aw(REG_CNT);

  logic                               i_rs_valid;
  logic [RD_PORTS-1:0][AW-1:0]        i_rs;
  logic                               i_write;
  logic [AW-1:0]                      i_rd;
  logic [XLEN-1:0]                    i_data;
  logic [RD_PORTS-1:0][XLEN-1:0]      o_data;
  logic                               o_ready;
  logic [AW-1:0]                      i_rd_tr;
  logic [XLEN-1:0]                    o_rd_tr;

  modport master (
    output i_rs_valid, i_rs, i_write, i_rd, i_data, i_rd_tr,
    input  o_data, o_ready, o_rd_tr
  );

  modport slave (
    input  i_rs_valid, i_rs, i_write, i_rd, i_data, i_rd_tr,
    output o_data, o_ready, o_rd_tr
  );

endinterface

// File: rtl/rv_regs_rdport.sv
// One registered read port: held address, output register, write-first bypass and x0 masking.
module rv_regs_rdport
  import rv_regs_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_clear,
  input  logic            i_rs_valid,
  input  logic [AW-1:0]   i_rs,
  output logic [AW-1:0]   o_eff,
  input  logic [XLEN-1:0] i_rdata,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0] o_data
);

  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_out;
  logic            w_hit;

  assign o_eff = i_rs_valid ? i_rs : r_addr;
  assign w_hit = (BYPASS != 0) && i_wr_en && (i_wr_addr == o_eff);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr <= '0;
      r_out  <= '0;
    end else begin
      if (i_rs_valid) r_addr <= i_rs;
      if (i_clear)    r_out  <= '0;
      else if (w_hit) r_out  <= i_wr_data;
      else            r_out  <= i_rdata;
    end
  end

  // Masking on the held address lets a port parked on x0 ignore whatever the output register holds.
  assign o_data = (r_addr == AW'(REGS_X0)) ? '0 : r_out;

endmodule

// File: rtl/rv_regfile.sv
// Parametrised integer register file: storage x1..x(REG_CNT-1), post-reset clear sequence, N read ports, trace read.
module rv_regfile
  import rv_regs_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_CNT        = 32,
  parameter int RD_PORTS       = 2,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  rv_regfile_if.slave  bus
);

  localparam int AW = regs_aw(REG_CNT);

  logic [XLEN-1:0] r_mem [1:REG_CNT-1];
  regs_state_t     r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_we, w_commit;
  logic [AW-1:0]   w_waddr;
  logic [XLEN-1:0] w_wdata;
  logic [AW-1:0]   w_eff   [RD_PORTS];
  logic [XLEN-1:0] w_rdata [RD_PORTS];
  logic [XLEN-1:0] w_odata [RD_PORTS];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      r_cnt   <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The clear sequence borrows the write port, so pipeline writes are dropped until READY.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    w_we        = 1'b0;
    w_waddr     = bus.i_rd;
    w_wdata     = bus.i_data;
    case (r_state)
      CLEAR: begin
        w_we      = 1'b1;
        w_waddr   = r_cnt;
        w_wdata   = '0;
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == AW'(REG_CNT - 1)) w_state_nxt = READY;
      end
      default: begin
        w_commit = bus.i_write && (bus.i_rd != AW'(REGS_X0));
        w_we     = w_commit;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    assign w_rdata[p] = (w_eff[p] == AW'(REGS_X0)) ? '0 : r_mem[w_eff[p]];

    rv_regs_rdport #(
      .XLEN   (XLEN),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_port (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_clear    (r_state == CLEAR),
      .i_rs_valid (bus.i_rs_valid),
      .i_rs       (bus.i_rs[p]),
      .o_eff      (w_eff[p]),
      .i_rdata    (w_rdata[p]),
      .i_wr_en    (w_commit),
      .i_wr_addr  (bus.i_rd),
      .i_wr_data  (bus.i_data),
      .o_data     (w_odata[p])
    );
  end

  always_comb begin
    bus.o_data = '0;
    for (int p = 0; p < RD_PORTS; p++) bus.o_data[p] = w_odata[p];
  end

  assign bus.o_ready = (r_state == READY);
  assign bus.o_rd_tr = (bus.i_rd_tr == AW'(REGS_X0)) ? '0 : r_mem[bus.i_rd_tr];

endmodule

// File: tb/tb_rv_regfile.sv
// Bench for rv_regfile: DUT A (32 regs, 2 ports, bypass) and DUT B (16 regs, 3 ports, no bypass).
module tb_rv_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int NP[2]  = '{2, 3};
  int CNT[2] = '{32, 16};
  int BYP[2] = '{1, 0};

  logic        rst_n [2];
  logic        s_rs_valid [2];
  logic [4:0]  s_rs [2][4];
  logic        s_write [2];
  logic [4:0]  s_rd [2];
  logic [31:0] s_data [2];
  logic [4:0]  s_tr [2];

  int n_checks = 0;
  int n_errors = 0;

  rv_regfile_if #(.XLEN(32), .REG_CNT(32), .RD_PORTS(2)) ifa ();
  rv_regfile_if #(.XLEN(32), .REG_CNT(16), .RD_PORTS(3)) ifb ();

  assign ifa.i_rs_valid = s_rs_valid[0];
  assign ifa.i_rs       = {s_rs[0][1], s_rs[0][0]};
  assign ifa.i_write    = s_write[0];
  assign ifa.i_rd       = s_rd[0];
  assign ifa.i_data     = s_data[0];
  assign ifa.i_rd_tr    = s_tr[0];
  assign ifb.i_rs_valid = s_rs_valid[1];
  assign ifb.i_rs       = {s_rs[1][2][3:0], s_rs[1][1][3:0], s_rs[1][0][3:0]};
  assign ifb.i_write    = s_write[1];
  assign ifb.i_rd       = s_rd[1][3:0];
  assign ifb.i_data     = s_data[1];
  assign ifb.i_rd_tr    = s_tr[1][3:0];

  rv_regfile #(.XLEN(32), .REG_CNT(32), .RD_PORTS(2), .BYPASS(1), .CLEAR_ON_RESET(1)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n[0]), .bus(ifa));
  rv_regfile #(.XLEN(32), .REG_CNT(16), .RD_PORTS(3), .BYPASS(0), .CLEAR_ON_RESET(1)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n[1]), .bus(ifb));

  // Reference model: architectural registers plus what each port last captured.
  bit [31:0] m_mem  [2][32];
  bit        m_ready[2];
  int        m_cnt  [2];
  int        m_held [2][4];
  bit [31:0] m_out  [2][4];
  int        m_eff  [4];
  bit        m_wr;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        m_ready[k] = 1'b0;
        m_cnt[k]   = 1;
        for (int p = 0; p < 4; p++) begin m_held[k][p] = 0; m_out[k][p] = '0; end
      end else begin
        for (int p = 0; p < NP[k]; p++) m_eff[p] = s_rs_valid[k] ? int'(s_rs[k][p]) : m_held[k][p];
        if (!m_ready[k]) begin
          for (int p = 0; p < NP[k]; p++) m_out[k][p] = '0;
          m_mem[k][m_cnt[k]] = '0;
          if (m_cnt[k] == CNT[k] - 1) m_ready[k] = 1'b1;
          m_cnt[k]++;
        end else begin
          m_wr = s_write[k] && (s_rd[k] != 0);
          for (int p = 0; p < NP[k]; p++)
            m_out[k][p] = (BYP[k] == 1 && m_wr && int'(s_rd[k]) == m_eff[p]) ? s_data[k] : m_mem[k][m_eff[p]];
          if (m_wr) m_mem[k][s_rd[k]] = s_data[k];
        end
        if (s_rs_valid[k]) for (int p = 0; p < NP[k]; p++) m_held[k][p] = int'(s_rs[k][p]);
      end
    end
  end

  function automatic logic [31:0] obs_data(int k, int p);
    if (k == 0) return ifa.o_data[p[0]];
    return ifb.o_data[p[1:0]];
  endfunction

  function automatic logic obs_ready(int k);
    return (k == 0) ? ifa.o_ready : ifb.o_ready;
  endfunction

  function automatic logic [31:0] obs_tr(int k);
    return (k == 0) ? ifa.o_rd_tr : ifb.o_rd_tr;
  endfunction

  function automatic bit [31:0] exp_data(int k, int p);
    return (m_held[k][p] == 0) ? 32'h0 : m_out[k][p];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      s_rs_valid[k] = 1'b0;
      s_write[k]    = 1'b0;
      s_rd[k]       = '0;
      s_data[k]     = '0;
      s_tr[k]       = '0;
      for (int p = 0; p < 4; p++) s_rs[k][p] = '0;
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_ready(k) !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_ready dut%0d: got %b expected 0", k, obs_ready(k));
      end
      for (int p = 0; p < NP[k]; p++) begin
        n_checks++;
        if (obs_data(k, p) !== 32'h0) begin
          n_errors++;
          $display("FAIL reset_data dut%0d p%0d: got %h expected 0", k, p, obs_data(k, p));
        end
      end
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
  endtask

  task automatic test_clear();
    for (int e = 1; e <= 31; e++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_ready(k) !== (e >= CNT[k] - 1)) begin
          n_errors++;
          $display("FAIL clear_ready dut%0d edge %0d: got %b expected %b", k, e, obs_ready(k), e >= CNT[k] - 1);
        end
      end
    end
    for (int i = 1; i <= 31; i++) begin
      s_rs_valid[0] = 1'b1;
      s_rs[0][0] = 5'(i);
      s_rs[0][1] = 5'(32 - i);
      step();
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (obs_data(0, p) !== 32'h0) begin
          n_errors++;
          $display("FAIL clear_read x%0d p%0d: got %h expected 0", i, p, obs_data(0, p));
        end
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    idle();
    s_write[0] = 1'b1; s_rd[0] = 5'd5; s_data[0] = 32'hDEADBEEF;
    step();
    idle();
    s_rs_valid[0] = 1'b1; s_rs[0][0] = 5'd5; s_rs[0][1] = 5'd0;
    step();
    n_checks++;
    if (obs_data(0, 0) !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL write_read rs1: got %h expected deadbeef", obs_data(0, 0));
    end
    n_checks++;
    if (obs_data(0, 1) !== 32'h0) begin
      n_errors++;
      $display("FAIL write_read rs2_x0: got %h expected 0", obs_data(0, 1));
    end
    idle();
  endtask

  task automatic test_hold();
    idle();
    s_rs_valid[0] = 1'b1; s_rs[0][0] = 5'd7; s_rs[0][1] = 5'd0;
    step();
    idle();
    s_write[0] = 1'b1; s_rd[0] = 5'd7; s_data[0] = 32'h12345678;
    step();
    idle();
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (obs_data(0, 0) !== 32'h12345678) begin
        n_errors++;
        $display("FAIL hold_track cycle %0d: got %h expected 12345678", c, obs_data(0, 0));
      end
      step();
    end
  endtask

  task automatic test_bypass();
    idle();
    for (int k = 0; k < 2; k++) begin s_write[k] = 1'b1; s_rd[k] = 5'd3; s_data[k] = 32'h11; end
    step();
    for (int k = 0; k < 2; k++) begin
      s_data[k] = 32'hA5A5A5A5;
      s_rs_valid[k] = 1'b1;
      for (int p = 0; p < 4; p++) s_rs[k][p] = 5'd3;
    end
    step();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP[k]; p++) begin
        n_checks++;
        if (obs_data(k, p) !== ((k == 0) ? 32'hA5A5A5A5 : 32'h11)) begin
          n_errors++;
          $display("FAIL bypass_same_edge dut%0d p%0d: got %h expected %h", k, p, obs_data(k, p),
                   (k == 0) ? 32'hA5A5A5A5 : 32'h11);
        end
      end
    idle();
    step();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP[k]; p++) begin
        n_checks++;
        if (obs_data(k, p) !== 32'hA5A5A5A5) begin
          n_errors++;
          $display("FAIL bypass_next_edge dut%0d p%0d: got %h expected a5a5a5a5", k, p, obs_data(k, p));
        end
      end
  endtask

  task automatic test_x0_and_clear_write();
    idle();
    s_write[0] = 1'b1; s_rd[0] = 5'd0; s_data[0] = 32'hFFFFFFFF;
    step();
    idle();
    s_tr[0] = 5'd0;
    #1;
    n_checks++;
    if (obs_tr(0) !== 32'h0) begin
      n_errors++;
      $display("FAIL x0_trace: got %h expected 0", obs_tr(0));
    end
    s_tr[0] = 5'd5;
    #1;
    n_checks++;
    if (obs_tr(0) !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL x0_no_alias x5: got %h expected deadbeef", obs_tr(0));
    end
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    s_write[0] = 1'b1; s_rd[0] = 5'd9; s_data[0] = 32'h55;
    for (int e = 1; e <= 31; e++) begin
      s_rs_valid[0] = (e == 5);
      s_rs[0][0] = 5'd9; s_rs[0][1] = 5'd4;
      step();
      n_checks++;
      if (obs_ready(0) !== (e >= 31) || obs_data(0, 0) !== 32'h0) begin
        n_errors++;
        $display("FAIL clear_write edge %0d: got ready=%b data=%h expected ready=%b data=0",
                 e, obs_ready(0), obs_data(0, 0), e >= 31);
      end
    end
    idle();
    s_tr[0] = 5'd9;
    #1;
    n_checks++;
    if (obs_tr(0) !== 32'h0) begin
      n_errors++;
      $display("FAIL clear_write_trace x9: got %h expected 0", obs_tr(0));
    end
    step();
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (obs_data(0, p) !== 32'h0) begin
        n_errors++;
        $display("FAIL clear_latched_read p%0d: got %h expected 0", p, obs_data(0, p));
      end
    end
    s_write[0] = 1'b1; s_rd[0] = 5'd4; s_data[0] = 32'h77;
    step();
    idle();
    n_checks++;
    if (obs_data(0, 1) !== 32'h77) begin
      n_errors++;
      $display("FAIL clear_latched_hold x4: got %h expected 77", obs_data(0, 1));
    end
  endtask

  task automatic test_reset_midclear();
    idle();
    #2;
    rst_n[1] = 1'b0;
    #1;
    n_checks++;
    if (obs_ready(1) !== 1'b0 || obs_data(1, 0) !== 32'h0 || obs_data(1, 2) !== 32'h0) begin
      n_errors++;
      $display("FAIL async_reset: got ready=%b d0=%h d2=%h expected 0", obs_ready(1), obs_data(1, 0), obs_data(1, 2));
    end
    step();
    rst_n[1] = 1'b1;
    for (int e = 1; e <= 8; e++) step();
    rst_n[1] = 1'b0;
    step();
    rst_n[1] = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      n_checks++;
      if (obs_ready(1) !== (e >= 15)) begin
        n_errors++;
        $display("FAIL reclear_ready edge %0d: got %b expected %b", e, obs_ready(1), e >= 15);
      end
    end
    s_write[1] = 1'b1; s_rd[1] = 5'd15; s_data[1] = 32'hCAFE0001;
    step();
    idle();
    s_rs_valid[1] = 1'b1;
    for (int p = 0; p < 3; p++) s_rs[1][p] = 5'd15;
    step();
    idle();
    for (int p = 0; p < 3; p++) begin
      n_checks++;
      if (obs_data(1, p) !== 32'hCAFE0001) begin
        n_errors++;
        $display("FAIL multi_port_x15 p%0d: got %h expected cafe0001", p, obs_data(1, p));
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      for (int k = 0; k < 2; k++) begin
        rst_n[k]      = ($urandom_range(0, 199) != 0);
        s_rs_valid[k] = $urandom_range(0, 1) == 1;
        for (int p = 0; p < 4; p++) s_rs[k][p] = 5'($urandom_range(0, CNT[k] - 1));
        s_write[k] = $urandom_range(0, 1) == 1;
        s_rd[k]    = 5'($urandom_range(0, CNT[k] - 1));
        s_data[k]  = $urandom;
        s_tr[k]    = 5'($urandom_range(0, CNT[k] - 1));
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_tr(k) !== ((s_tr[k] == 0) ? 32'h0 : m_mem[k][s_tr[k]])) begin
          n_errors++;
          $display("FAIL rand_trace dut%0d it%0d x%0d: got %h expected %h", k, it, s_tr[k], obs_tr(k),
                   (s_tr[k] == 0) ? 32'h0 : m_mem[k][s_tr[k]]);
        end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_ready(k) !== m_ready[k]) begin
          n_errors++;
          $display("FAIL rand_ready dut%0d it%0d: got %b expected %b", k, it, obs_ready(k), m_ready[k]);
        end
        for (int p = 0; p < NP[k]; p++) begin
          n_checks++;
          if (obs_data(k, p) !== exp_data(k, p)) begin
            n_errors++;
            $display("FAIL rand_data dut%0d it%0d p%0d: got %h expected %h", k, it, p, obs_data(k, p), exp_data(k, p));
          end
        end
      end
    end
    idle();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    test_reset();
    test_clear();
    test_write_read();
    test_hold();
    test_bypass();
    test_x0_and_clear_write();
    test_reset_midclear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
